// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the button conditioner and its debouncers.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } deb_state_t;

  localparam int unsigned LETTER_W = 3;

endpackage

// File: rtl/button_conditioner_debounce_fsm.sv
// One push-button debouncer: synchronizers, stability counter, press FSM and
// letter capture. accept pulses combinationally in the cycle a press is taken.
module debounce_fsm
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_raw,
  input  logic [LETTER_W-1:0] letter_raw,
  output logic                accept,
  output logic [LETTER_W-1:0] letter
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

  logic                btn_meta;
  logic                btn_sync;
  logic [LETTER_W-1:0] letter_meta;
  logic [LETTER_W-1:0] letter_sync;
  logic [LETTER_W-1:0] letter_q;
  deb_state_t          state;
  deb_state_t          state_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [CNT_W-1:0]    cnt_inc;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta    <= 1'b0;
      btn_sync    <= 1'b0;
      letter_meta <= '0;
      letter_sync <= '0;
      letter_q    <= '0;
      state       <= IDLE;
      cnt         <= '0;
    end else begin
      btn_meta    <= btn_raw;
      btn_sync    <= btn_meta;
      letter_meta <= letter_raw;
      letter_sync <= letter_meta;
      state       <= state_next;
      cnt         <= cnt_next;
      if (accept) begin
        letter_q <= letter_sync;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_sync) begin
          state_next = ARMING;
          cnt_next   = '0;
        end
      end
      ARMING: begin
        if (!btn_sync) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_next = HELD;
            accept     = 1'b1;
          end
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_next = RELEASING;
          cnt_next   = '0;
        end
      end
      RELEASING: begin
        if (btn_sync) begin
          state_next = HELD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Bypass so the top can register the letter in the same edge it is captured.
  assign letter = accept ? letter_sync : letter_q;

endmodule

// File: rtl/button_conditioner.sv
// Two debounced buttons feeding a single pulse/letter output pair; A wins ties
// and a B acceptance that collides with A is deferred, never dropped.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btnA_raw,
  input  logic                btnB_raw,
  input  logic [LETTER_W-1:0] letterRaw,
  output logic                enterA,
  output logic                enterB,
  output logic [LETTER_W-1:0] letterIn
);

  logic                accept_a;
  logic                accept_b;
  logic [LETTER_W-1:0] letter_a;
  logic [LETTER_W-1:0] letter_b;
  logic                pend_b;

  debounce_fsm #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_a (
    .clk       (clk),
    .rst_n     (rst),
    .btn_raw   (btnA_raw),
    .letter_raw(letterRaw),
    .accept    (accept_a),
    .letter    (letter_a)
  );

  debounce_fsm #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_b (
    .clk       (clk),
    .rst_n     (rst),
    .btn_raw   (btnB_raw),
    .letter_raw(letterRaw),
    .accept    (accept_b),
    .letter    (letter_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enterA   <= 1'b0;
      enterB   <= 1'b0;
      letterIn <= '0;
      pend_b   <= 1'b0;
    end else begin
      enterA <= 1'b0;
      enterB <= 1'b0;
      if (accept_a) begin
        enterA   <= 1'b1;
        letterIn <= letter_a;
        pend_b   <= pend_b | accept_b;
      end else if (accept_b || pend_b) begin
        // B's captured letter stays in its debouncer until its next press.
        enterB   <= 1'b1;
        letterIn <= letter_b;
        pend_b   <= 1'b0;
      end
    end
  end

endmodule
